// File: rtl/blink_seq_pkg.sv
// Shared types for the blink sequencer: pattern modes and FSM states.
package blink_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ALL    = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BURST  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/blink_prescaler.sv
// Step prescaler: counts 0..TICK_DIV-1 while enabled, flags the terminal count.
module blink_prescaler #(
  parameter int unsigned TICK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick fires on the enabled cycle that sees the terminal count.
  assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

  // Next count: clear wins, then wrap at the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/blink_sequencer.sv
// Pattern sequencer driving blinker switch enables (ALL / CHASE / BOUNCE / BURST).
// Define BLINK_SEQ_BURST_EN to build BURST mode, its counter and the done pulse.
module blink_sequencer
  import blink_seq_pkg::*;
#(
  parameter int unsigned N_LEDS    = 4,
  parameter int unsigned TICK_DIV  = 8,
  parameter int unsigned BURST_LEN = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [N_LEDS-1:0] switch_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned SW = $clog2(N_LEDS) + 1;
  localparam logic [N_LEDS-1:0] ONE_HOT0 = N_LEDS'(1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [SW-1:0]     step_q, step_d;
  logic              dir_q, dir_d;
  logic [N_LEDS-1:0] switch_q, switch_d;
  logic              busy_q, busy_d;
  logic              tick_c;
  logic              pre_en_c;
  logic              pre_clr_c;
  logic              start_acc_c;

`ifdef BLINK_SEQ_BURST_EN
  localparam int unsigned BW = $clog2(BURST_LEN + 1);
  logic [BW-1:0]     burst_q, burst_d;
  logic              done_q, done_d;
`endif

  assign start_acc_c = (state_q == ST_IDLE) && start && !stop;
  assign pre_en_c    = (state_q != ST_IDLE) && !stop && !pause;
  assign pre_clr_c   = start_acc_c || (state_d == ST_IDLE);

  blink_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (pre_en_c),
    .clr   (pre_clr_c),
    .tick  (tick_c)
  );

  // Next-state, step advance and registered-output values.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    step_d   = step_q;
    dir_d    = dir_q;
    switch_d = '0;
    busy_d   = 1'b0;
`ifdef BLINK_SEQ_BURST_EN
    burst_d  = burst_q;
    done_d   = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_acc_c) begin
          state_d = ST_RUN;
`ifdef BLINK_SEQ_BURST_EN
          mode_d  = mode_e'(mode);
          burst_d = '0;
`else
          mode_d  = (mode_e'(mode) == MODE_BURST) ? MODE_ALL : mode_e'(mode);
`endif
          step_d  = '0;
          dir_d   = 1'b0;
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
          if (tick_c) begin
            unique case (mode_q)
              MODE_CHASE: begin
                step_d = (step_q == SW'(N_LEDS - 1)) ? '0 : step_q + SW'(1);
              end
              MODE_BOUNCE: begin
                if (!dir_q) begin
                  if (step_q == SW'(N_LEDS - 1)) begin
                    dir_d  = 1'b1;
                    step_d = step_q - SW'(1);
                  end else begin
                    step_d = step_q + SW'(1);
                  end
                end else begin
                  if (step_q == '0) begin
                    dir_d  = 1'b0;
                    step_d = SW'(1);
                  end else begin
                    step_d = step_q - SW'(1);
                  end
                end
              end
`ifdef BLINK_SEQ_BURST_EN
              MODE_BURST: begin
                if (burst_q == BW'(BURST_LEN - 1)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                end else begin
                  burst_d = burst_q + BW'(1);
                end
              end
`endif
              default: begin
                step_d = step_q;
              end
            endcase
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs reflect the state being entered, so they move on the same edge.
    if (state_d != ST_IDLE) begin
      busy_d = 1'b1;
      if ((mode_d == MODE_CHASE) || (mode_d == MODE_BOUNCE)) begin
        switch_d = ONE_HOT0 << step_d;
      end else begin
        switch_d = '1;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_ALL;
      step_q   <= '0;
      dir_q    <= 1'b0;
      switch_q <= '0;
      busy_q   <= 1'b0;
`ifdef BLINK_SEQ_BURST_EN
      burst_q  <= '0;
      done_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      switch_q <= switch_d;
      busy_q   <= busy_d;
`ifdef BLINK_SEQ_BURST_EN
      burst_q  <= burst_d;
      done_q   <= done_d;
`endif
    end
  end

  assign switch_out = switch_q;
  assign busy       = busy_q;
`ifdef BLINK_SEQ_BURST_EN
  assign done       = done_q;
`else
  assign done       = 1'b0;
`endif

endmodule
